// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit saturating counters, resolve-stage
// mispredict detection/redirect and saturating branch/miss statistics.
module branch_predictor #(
  parameter int WIDTH   = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pc_if,
  output logic             pred_taken,
  output logic [WIDTH-1:0] pred_target,
  input  logic             upd_valid,
  input  logic [WIDTH-1:0] upd_pc,
  input  logic             upd_taken,
  input  logic [WIDTH-1:0] upd_target,
  input  logic             upd_pred_taken,
  input  logic [WIDTH-1:0] upd_pred_target,
  input  logic             flush_all,
  output logic             mispredict,
  output logic [WIDTH-1:0] redirect_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] miss_cnt
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = WIDTH - 2 - IDX_W;
  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [WIDTH-1:0]   tgt_q [ENTRIES];
  logic [1:0]         cnt_q [ENTRIES];
  logic [IDX_W-1:0]   li, ui;
  logic [TAG_W-1:0]   lt, ut;
  logic               hit, uhit, wr_tgt;
  assign li = pc_if[IDX_W+1:2];
  assign lt = pc_if[WIDTH-1:IDX_W+2];
  assign ui = upd_pc[IDX_W+1:2];
  assign ut = upd_pc[WIDTH-1:IDX_W+2];
  assign hit  = valid[li] && tag_q[li] == lt;
  assign uhit = valid[ui] && tag_q[ui] == ut;
  assign pred_taken  = hit && cnt_q[li][1];
  assign pred_target = pred_taken ? tgt_q[li] : pc_if + WIDTH'(4);
  assign mispredict  = upd_valid && (upd_taken != upd_pred_taken ||
                       (upd_taken && upd_pred_taken && upd_target != upd_pred_target));
  assign redirect_pc = upd_taken ? upd_target : upd_pc + WIDTH'(4);
  // Taken updates write the target on both hit and allocate; tag only on allocate.
  assign wr_tgt = rst_n && upd_valid && upd_taken && !flush_all;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid      <= '0;
      branch_cnt <= '0;
      miss_cnt   <= '0;
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= 2'b01;
    end else begin
      branch_cnt <= branch_cnt + CNT_W'(upd_valid && branch_cnt != '1);
      miss_cnt   <= miss_cnt + CNT_W'(mispredict && miss_cnt != '1);
      if (flush_all) valid <= '0;
      else if (upd_valid && uhit)
        cnt_q[ui] <= upd_taken ? cnt_q[ui] + 2'(cnt_q[ui] != 2'b11)
                               : cnt_q[ui] - 2'(cnt_q[ui] != 2'b00);
      else if (upd_valid && upd_taken) begin
        valid[ui] <= 1'b1;
        cnt_q[ui] <= 2'b10;
      end
    end
  always_ff @(posedge clk)
    if (wr_tgt) begin
      tgt_q[ui] <= upd_target;
      if (!uhit) tag_q[ui] <= ut;
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed vectors; expectations queued by stimulus, checked by a negedge monitor.
module tb_branch_predictor;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [31:0] pc_if, upd_pc, upd_target, upd_pred_target, pred_target, redirect_pc;
  logic        pred_taken, upd_valid, upd_taken, upd_pred_taken, flush_all, mispredict;
  logic [15:0] branch_cnt, miss_cnt;
  logic [31:0] s_ptgt, s_redir;
  logic        s_pt, s_mis, s_upd_valid;
  logic [3:0]  s_bcnt, s_mcnt;

  branch_predictor dut (
    .clk(clk), .rst_n(rst_n), .pc_if(pc_if), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target), .flush_all(flush_all),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .branch_cnt(branch_cnt), .miss_cnt(miss_cnt)
  );

  branch_predictor #(.CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .pc_if(pc_if), .pred_taken(s_pt), .pred_target(s_ptgt),
    .upd_valid(s_upd_valid), .upd_pc(32'h100), .upd_taken(1'b1), .upd_target(32'h80),
    .upd_pred_taken(1'b0), .upd_pred_target(32'h104), .flush_all(1'b0),
    .mispredict(s_mis), .redirect_pc(s_redir), .branch_cnt(s_bcnt), .miss_cnt(s_mcnt)
  );

  typedef struct { int kind; logic [31:0] val; } exp_t;
  exp_t sb[$];
  int checks = 0, passed = 0;

  function automatic logic [31:0] act(int k);
    case (k)
      0: return {31'd0, pred_taken};
      1: return pred_target;
      2: return {31'd0, mispredict};
      3: return redirect_pc;
      4: return {16'd0, branch_cnt};
      5: return {16'd0, miss_cnt};
      6: return {28'd0, s_bcnt};
      default: return {28'd0, s_mcnt};
    endcase
  endfunction

  function automatic string nm(int k);
    case (k)
      0: return "pred_taken";
      1: return "pred_target";
      2: return "mispredict";
      3: return "redirect_pc";
      4: return "branch_cnt";
      5: return "miss_cnt";
      6: return "sat_branch_cnt";
      default: return "sat_miss_cnt";
    endcase
  endfunction

  always @(negedge clk)
    while (sb.size() > 0) begin
      exp_t e;
      logic [31:0] a;
      e = sb.pop_front();
      a = act(e.kind);
      checks++;
      if (a === e.val) passed++;
      else $display("FAIL %s @%0t: got %h expected %h", nm(e.kind), $time, a, e.val);
    end

  task automatic chk(int k, logic [31:0] v);
    sb.push_back('{k, v});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(logic [31:0] pc, logic tk, logic [31:0] tgt, logic ptk, logic [31:0] ptgt);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    upd_pred_taken = ptk; upd_pred_target = ptgt;
  endtask

  task automatic look(logic [31:0] pc, logic tk, logic [31:0] tgt);
    pc_if = pc;
    chk(0, {31'd0, tk});
    chk(1, tgt);
  endtask

  initial begin
    pc_if = 32'h100; upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
    upd_pred_taken = 0; upd_pred_target = 0; flush_all = 0; s_upd_valid = 0;
    look(32'h100, 0, 32'h104); chk(4, 0); chk(5, 0);
    step(); rst_n = 1'b1;
    look(32'h100, 0, 32'h104);
    // train and redirect; same-cycle lookup still sees old contents
    step(); upd(32'h100, 1, 32'h80, 0, 32'h104);
    look(32'h100, 0, 32'h104); chk(2, 1); chk(3, 32'h80); chk(4, 0);
    step(); upd_valid = 0;
    look(32'h100, 1, 32'h80); chk(4, 1); chk(5, 1);
    // hysteresis: two taken to saturate, two not-taken to flip
    step(); upd(32'h100, 1, 32'h80, 1, 32'h80); chk(2, 0);
    step(); chk(2, 0); chk(4, 2);
    step(); upd(32'h100, 0, 32'h80, 1, 32'h80); chk(2, 1); chk(3, 32'h104); chk(4, 3); chk(5, 1);
    step(); upd_valid = 0;
    look(32'h100, 1, 32'h80); chk(4, 4); chk(5, 2);
    step(); upd(32'h100, 0, 32'h80, 1, 32'h80); chk(2, 1);
    step(); upd_valid = 0;
    look(32'h100, 0, 32'h104); chk(4, 5); chk(5, 3);
    // aliasing between 0x100 and 0x140 at index 0
    step(); upd(32'h100, 1, 32'h80, 0, 32'h104);
    step(); upd_valid = 0;
    look(32'h100, 1, 32'h80); chk(4, 6); chk(5, 4);
    step(); look(32'h140, 0, 32'h144);
    step(); upd(32'h140, 1, 32'h200, 0, 32'h144); chk(2, 1); chk(3, 32'h200);
    look(32'h140, 0, 32'h144);
    step(); upd_valid = 0;
    look(32'h140, 1, 32'h200); chk(4, 7); chk(5, 5);
    step(); look(32'h100, 0, 32'h104);
    // taken-taken with a different target
    step(); upd(32'h140, 1, 32'h90, 1, 32'h200); chk(2, 1); chk(3, 32'h90);
    look(32'h140, 1, 32'h200);
    step(); upd_valid = 0;
    look(32'h140, 1, 32'h90); chk(4, 8); chk(5, 6);
    // flush overrides a simultaneous taken update but stats still count
    step(); flush_all = 1; upd(32'h100, 1, 32'h80, 0, 32'h104); chk(2, 1);
    step(); flush_all = 0; upd_valid = 0;
    look(32'h140, 0, 32'h144); chk(4, 9); chk(5, 7);
    step(); look(32'h100, 0, 32'h104);
    // not-taken miss leaves table unchanged
    step(); upd(32'h100, 1, 32'h80, 0, 32'h104);
    step(); upd(32'h180, 0, 32'h0, 0, 32'h0); chk(2, 0); chk(3, 32'h184);
    step(); upd_valid = 0;
    look(32'h100, 1, 32'h80); chk(4, 11); chk(5, 8);
    // reset mid-update aborts it
    step(); upd(32'h140, 1, 32'h300, 0, 32'h144); rst_n = 1'b0;
    look(32'h140, 0, 32'h144); chk(2, 1); chk(3, 32'h300); chk(4, 0); chk(5, 0);
    step(); rst_n = 1'b1; upd_valid = 0;
    look(32'h140, 0, 32'h144); chk(4, 0);
    step(); look(32'h100, 0, 32'h104);
    // statistics saturation with a 4-bit counter instance
    step(); s_upd_valid = 1;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk(7, (i > 15) ? 32'd15 : 32'(i));
    end
    chk(6, 15);
    step(); s_upd_valid = 0;
    #1;
    checks++;
    if (s_mcnt === 4'hF) passed++;
    else $display("FAIL direct sat_miss_cnt: got %h expected f", s_mcnt);
    checks++;
    if (s_bcnt === 4'hF) passed++;
    else $display("FAIL direct sat_branch_cnt: got %h expected f", s_bcnt);
    checks++;
    if (s_mis === 1'b0) passed++;
    else $display("FAIL direct sat_mispredict: got %b expected 0", s_mis);
    @(negedge clk); #1;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      $display("FAIL %s: never compared, expected %h", nm(e.kind), e.val);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
